// File: rtl/id_issue_stage.sv
// Decode/issue stage: decodes one MIPS instruction per cycle, reads operands and
// issues through a valid/ready ID/EX register guarded by a pending-write scoreboard.
module id_issue_stage #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int REG_W = 5,
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [XLEN-1:0]  in_pc,
   input  logic             in_pred_taken,
   output logic [REG_W-1:0] rf_src1,
   output logic [REG_W-1:0] rf_src2,
   input  logic [XLEN-1:0]  rf_out1,
   input  logic [XLEN-1:0]  rf_out2,
   input  logic             wb_valid,
   input  logic [REG_W-1:0] wb_dest,
   input  logic [XLEN-1:0]  wb_data,
   input  logic             flush,
   output logic             redirect,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [5:0]       out_alu_op,
   output logic [XLEN-1:0]  out_src1,
   output logic [XLEN-1:0]  out_src2,
   output logic [REG_W-1:0] out_rf_dest,
   output logic [XLEN-1:0]  out_mem_data,
   output logic             out_is_load,
   output logic             out_is_store,
   output logic             out_is_branch,
   output logic [XLEN-1:0]  out_pc,
   output logic             out_pred_taken
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [5:0]       opcode, funct;
   logic [4:0]       shamt;
   logic [REG_W-1:0] rs, rt, rd, dest, raw_src1;
   logic             is_r, is_j, is_jal, is_jr, is_br, is_ld, is_st, is_alui, is_shift, zext;
   logic [XLEN-1:0]  v1, v2, imm, src1, src2;
   logic             hazard, waw, accept;
   logic [CNT_W-1:0] cnt     [NREG];
   logic [CNT_W-1:0] cnt_nxt [NREG];

   function automatic logic raw(input logic [REG_W-1:0] s, input logic [CNT_W-1:0] c,
                                input logic wbv, input logic [REG_W-1:0] wbd);
      return (s != '0) && (c != '0) && !((c == CNT_W'(1)) && wbv && (wbd == s));
   endfunction

   assign opcode   = in_inst[31:26];
   assign rs       = REG_W'(in_inst[25:21]);
   assign rt       = REG_W'(in_inst[20:16]);
   assign rd       = REG_W'(in_inst[15:11]);
   assign shamt    = in_inst[10:6];
   assign funct    = in_inst[5:0];

   assign is_r     = (opcode == 6'h00);
   assign is_j     = (opcode == 6'h02);
   assign is_jal   = (opcode == 6'h03);
   assign is_jr    = is_r && (funct == 6'h08);
   assign is_br    = opcode inside {[6'h04:6'h07]};
   assign is_ld    = opcode inside {[6'h20:6'h26]};
   assign is_st    = opcode inside {6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E};
   assign is_alui  = opcode inside {[6'h08:6'h0F]};
   assign is_shift = is_r && (funct inside {6'h00, 6'h02, 6'h03});
   assign zext     = opcode inside {[6'h0C:6'h0F]};

   assign rf_src1  = rs;
   assign rf_src2  = (is_r || is_br || is_st) ? rt : '0;
   // J/JAL carry a jump index in the rs field, so it is not a real source.
   assign raw_src1 = (is_j || is_jal) ? '0 : rs;

   always_comb begin
      dest = '0;
      if (is_r && !is_jr)      dest = rd;
      else if (is_jal)         dest = REG_W'(5'd31);
      else if (is_ld || is_alui) dest = rt;
   end

   assign v1   = (wb_valid && wb_dest == rf_src1 && rf_src1 != '0) ? wb_data : rf_out1;
   assign v2   = (wb_valid && wb_dest == rf_src2 && rf_src2 != '0) ? wb_data : rf_out2;
   assign imm  = zext ? {{(XLEN-16){1'b0}}, in_inst[15:0]} : {{(XLEN-16){in_inst[15]}}, in_inst[15:0]};
   assign src1 = is_shift ? {{(XLEN-5){1'b0}}, shamt} : (is_jal ? in_pc : v1);
   assign src2 = (is_r || is_br) ? v2 : (is_jal ? XLEN'(4) : imm);

   assign waw      = (dest != '0) && (cnt[dest] == CNT_MAX) && !(wb_valid && wb_dest == dest);
   assign hazard   = raw(raw_src1, cnt[raw_src1], wb_valid, wb_dest) ||
                     raw(rf_src2, cnt[rf_src2], wb_valid, wb_dest) || waw;
   assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
   assign accept   = in_valid && in_ready;

   assign redirect    = accept && (is_j || is_jal || is_jr);
   assign redirect_pc = is_jr ? v1 : {in_pc[XLEN-1:28], in_inst[25:0], 2'b00};

   // Scoreboard next state: accept increments, retiring writes and squashed bundles decrement.
   always_comb begin
      logic inc, dwb, dfl;
      inc = 1'b0;
      dwb = 1'b0;
      dfl = 1'b0;
      cnt_nxt = cnt;
      cnt_nxt[0] = '0;
      for (int r = 1; r < NREG; r++) begin
         inc = accept && (dest == REG_W'(r));
         dwb = wb_valid && (wb_dest == REG_W'(r)) && (cnt[r] != '0);
         dfl = flush && out_valid && (out_rf_dest == REG_W'(r));
         if (inc)
            cnt_nxt[r] = dwb ? cnt[r] : cnt[r] + CNT_W'(1);
         else if (dwb && dfl)
            cnt_nxt[r] = (cnt[r] > CNT_W'(1)) ? cnt[r] - CNT_W'(2) : '0;
         else if (dwb || dfl)
            cnt_nxt[r] = (cnt[r] != '0) ? cnt[r] - CNT_W'(1) : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

   // ID/EX register: loads only on accept so a stalled bundle holds still.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         out_alu_op     <= '0;
         out_src1       <= '0;
         out_src2       <= '0;
         out_rf_dest    <= '0;
         out_mem_data   <= '0;
         out_is_load    <= 1'b0;
         out_is_store   <= 1'b0;
         out_is_branch  <= 1'b0;
         out_pc         <= '0;
         out_pred_taken <= 1'b0;
      end else if (accept) begin
         out_valid      <= 1'b1;
         out_alu_op     <= is_r ? funct : opcode;
         out_src1       <= src1;
         out_src2       <= src2;
         out_rf_dest    <= dest;
         out_mem_data   <= v2;
         out_is_load    <= is_ld;
         out_is_store   <= is_st;
         out_is_branch  <= is_br;
         out_pc         <= in_pc;
         out_pred_taken <= in_pred_taken;
      end else if (flush || out_ready) begin
         out_valid      <= 1'b0;
      end
   end
endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: stimulus pushes expected bundles into a queue,
// a negedge monitor pops and compares each bundle EX consumes.
module tb_id_issue_stage;
   typedef logic [142:0] bundle_t;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, in_pred_taken;
   logic [31:0] in_inst, in_pc;
   logic [4:0]  rf_src1, rf_src2, wb_dest, out_rf_dest;
   logic [31:0] rf_out1, rf_out2, wb_data, redirect_pc;
   logic        wb_valid, flush, redirect, out_valid, out_ready;
   logic [5:0]  out_alu_op;
   logic [31:0] out_src1, out_src2, out_mem_data, out_pc;
   logic        out_is_load, out_is_store, out_is_branch, out_pred_taken;

   logic [31:0] tb_rf [32] = '{default: '0};
   bundle_t     expq [$];
   int          checks = 0;
   int          errors = 0;

   id_issue_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .in_pred_taken(in_pred_taken),
      .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_out1(rf_out1), .rf_out2(rf_out2),
      .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data), .flush(flush),
      .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
      .out_ready(out_ready), .out_alu_op(out_alu_op), .out_src1(out_src1),
      .out_src2(out_src2), .out_rf_dest(out_rf_dest), .out_mem_data(out_mem_data),
      .out_is_load(out_is_load), .out_is_store(out_is_store),
      .out_is_branch(out_is_branch), .out_pc(out_pc), .out_pred_taken(out_pred_taken)
   );

   always #5 clk = ~clk;

   assign rf_out1 = (rf_src1 == 5'd0) ? 32'd0 : tb_rf[rf_src1];
   assign rf_out2 = (rf_src2 == 5'd0) ? 32'd0 : tb_rf[rf_src2];
   always @(posedge clk) if (wb_valid && wb_dest != 5'd0) tb_rf[wb_dest] <= wb_data;

   function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
   endfunction
   function automatic logic [31:0] enc_i(int op, int rs, int rt, logic [15:0] imm);
      return {6'(op), 5'(rs), 5'(rt), imm};
   endfunction
   function automatic bundle_t mk(logic [5:0] alu, logic [31:0] s1, logic [31:0] s2,
                                  logic [4:0] d, logic [31:0] mem, logic [2:0] fl,
                                  logic [31:0] pc, logic pred);
      return {alu, s1, s2, d, mem, fl, pc, pred};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
      in_valid = 1'b1;
      in_inst  = inst;
      in_pc    = pc;
   endtask

   task automatic wb(input int d, input logic [31:0] v);
      wb_valid = 1'b1;
      wb_dest  = 5'(d);
      wb_data  = v;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready && !flush) begin
         if (expq.size() == 0) begin
            chk("unexpected_bundle", {32'd0, out_pc}, 64'hFFFF_FFFF);
         end else begin
            bundle_t e;
            e = expq.pop_front();
            checks++;
            if ({out_alu_op, out_src1, out_src2, out_rf_dest, out_mem_data, out_is_load,
                 out_is_store, out_is_branch, out_pc, out_pred_taken} !== e) begin
               errors++;
               $display("FAIL bundle pc=%0h actual=%0h required=%0h", out_pc,
                        {out_alu_op, out_src1, out_src2, out_rf_dest, out_mem_data, out_is_load,
                         out_is_store, out_is_branch, out_pc, out_pred_taken}, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; in_pred_taken = 1'b0;
      wb_valid = 1'b0; wb_dest = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
      step(); step();
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_redirect", 64'(redirect), 64'd0);
      chk("reset_src1", 64'(out_src1), 64'd0);
      rst_n = 1'b1;
      step();

      // Mid-stream asynchronous reset with a held bundle and cnt[8]=2.
      offer(enc_i(8, 0, 8, 16'd5), 32'h100);
      expq.push_back(mk(6'h08, 32'd0, 32'd5, 5'd8, 32'd0, 3'b000, 32'h100, 1'b0));
      step();
      offer(enc_i(8, 0, 8, 16'd5), 32'h104);
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("pre_reset_cnt8", 64'(dut.cnt[8]), 64'd2);
      chk("pre_reset_valid", 64'(out_valid), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_reset_valid", 64'(out_valid), 64'd0);
      chk("async_reset_src2", 64'(out_src2), 64'd0);
      chk("async_reset_dest", 64'(out_rf_dest), 64'd0);
      chk("async_reset_cnt8", 64'(dut.cnt[8]), 64'd0);
      step();
      rst_n = 1'b1; out_ready = 1'b1;
      step();

      // RAW hazard resolved by the retiring writeback with bypass.
      offer(enc_i(8, 0, 8, 16'd5), 32'h200);
      expq.push_back(mk(6'h08, 32'd0, 32'd5, 5'd8, 32'd0, 3'b000, 32'h200, 1'b0));
      step();
      offer(enc_r(8, 8, 9, 0, 6'h20), 32'h204);
      #1 chk("raw_stall_0", 64'(in_ready), 64'd0);
      step();
      chk("raw_stall_1", 64'(in_ready), 64'd0);
      wb(8, 32'd5);
      #1 chk("raw_release", 64'(in_ready), 64'd1);
      expq.push_back(mk(6'h20, 32'd5, 32'd5, 5'd9, 32'd5, 3'b000, 32'h204, 1'b0));
      step();
      in_valid = 1'b0; wb_valid = 1'b0;
      #1;
      chk("raw_cnt8", 64'(dut.cnt[8]), 64'd0);
      chk("raw_cnt9", 64'(dut.cnt[9]), 64'd1);
      wb(9, 32'd10);
      step();
      wb_valid = 1'b0;
      #1 chk("wb_cnt9", 64'(dut.cnt[9]), 64'd0);

      // Zero- vs sign-extended immediates.
      offer(enc_i(6'h0D, 0, 3, 16'h8000), 32'h300);
      expq.push_back(mk(6'h0D, 32'd0, 32'h0000_8000, 5'd3, 32'd0, 3'b000, 32'h300, 1'b0));
      step();
      offer(enc_i(6'h08, 0, 3, 16'hFFFF), 32'h304);
      in_pred_taken = 1'b1;
      expq.push_back(mk(6'h08, 32'd0, 32'hFFFF_FFFF, 5'd3, 32'd0, 3'b000, 32'h304, 1'b1));
      step();
      in_valid = 1'b0; in_pred_taken = 1'b0;
      wb(3, 32'h33); step(); step();
      wb_valid = 1'b0;
      #1 chk("imm_cnt3", 64'(dut.cnt[3]), 64'd0);

      // Scoreboard capacity: three writes to r4 fit, a fourth waits for a writeback.
      for (int i = 1; i <= 3; i++) begin
         offer(enc_i(8, 0, 4, 16'(i)), 32'h400 + 32'(4 * (i - 1)));
         expq.push_back(mk(6'h08, 32'd0, 32'(i), 5'd4, 32'd0, 3'b000, 32'h400 + 32'(4 * (i - 1)), 1'b0));
         step();
      end
      offer(enc_i(8, 0, 4, 16'd4), 32'h40C);
      #1;
      chk("cap_stall_0", 64'(in_ready), 64'd0);
      chk("cap_cnt4_full", 64'(dut.cnt[4]), 64'd3);
      step();
      chk("cap_stall_1", 64'(in_ready), 64'd0);
      wb(4, 32'h44);
      #1 chk("cap_release", 64'(in_ready), 64'd1);
      expq.push_back(mk(6'h08, 32'd0, 32'd4, 5'd4, 32'd0, 3'b000, 32'h40C, 1'b0));
      step();
      in_valid = 1'b0;
      #1 chk("cap_cnt4_net", 64'(dut.cnt[4]), 64'd3);
      step(); step(); step();
      wb_valid = 1'b0;
      #1 chk("cap_cnt4_drain", 64'(dut.cnt[4]), 64'd0);

      // Back-pressure: held bundle stays stable and the stage refuses new work.
      out_ready = 1'b0;
      offer(enc_i(8, 0, 5, 16'd7), 32'h500);
      expq.push_back(mk(6'h08, 32'd0, 32'd7, 5'd5, 32'd0, 3'b000, 32'h500, 1'b0));
      step();
      offer(enc_i(8, 0, 6, 16'd8), 32'h504);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("hold_bundle", {out_src2, 27'd0, out_rf_dest}, {32'd7, 27'd0, 5'd5});
         chk("hold_in_ready", 64'(in_ready), 64'd0);
         step();
      end
      out_ready = 1'b1;
      #1 chk("hold_release", 64'(in_ready), 64'd1);
      expq.push_back(mk(6'h08, 32'd0, 32'd8, 5'd6, 32'd0, 3'b000, 32'h504, 1'b0));
      step();
      in_valid = 1'b0;
      #1 chk("hold_next_dest", 64'(out_rf_dest), 64'd6);
      wb(5, 32'd7); step();
      wb(6, 32'd8); step();
      wb_valid = 1'b0;

      // Store and JR.
      offer(enc_i(6'h2B, 4, 9, 16'd8), 32'h580);
      expq.push_back(mk(6'h2B, 32'h44, 32'd8, 5'd0, 32'd10, 3'b010, 32'h580, 1'b0));
      #1 chk("store_no_redirect", 64'(redirect), 64'd0);
      step();
      offer(enc_r(9, 0, 0, 0, 6'h08), 32'h590);
      expq.push_back(mk(6'h08, 32'd10, 32'd0, 5'd0, 32'd0, 3'b000, 32'h590, 1'b0));
      #1;
      chk("jr_redirect", 64'(redirect), 64'd1);
      chk("jr_target", 64'(redirect_pc), 64'd10);
      step();

      // JAL then flush.
      offer({6'h03, 26'h0100020}, 32'h0040_0010);
      #1;
      chk("jal_redirect", 64'(redirect), 64'd1);
      chk("jal_target", 64'(redirect_pc), 64'h0040_0080);
      step();
      in_valid = 1'b0;
      chk("jal_valid", 64'(out_valid), 64'd1);
      chk("jal_dest", 64'(out_rf_dest), 64'd31);
      chk("jal_src1", 64'(out_src1), 64'h0040_0010);
      chk("jal_src2", 64'(out_src2), 64'd4);
      chk("jal_cnt31", 64'(dut.cnt[31]), 64'd1);
      flush = 1'b1;
      offer(enc_r(0, 0, 0, 0, 6'h08), 32'h0040_0014);
      #1;
      chk("flush_in_ready", 64'(in_ready), 64'd0);
      chk("flush_no_redirect", 64'(redirect), 64'd0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_cnt31", 64'(dut.cnt[31]), 64'd0);
      step(); step();
      chk("queue_drained", 64'(expq.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/id_issue_stage.md
Name: id_issue_stage

Overview:
- Registered, parametrised decode/issue stage for the MIPS pipeline.
- Decodes one instruction per cycle into ALU and memory controls, and reads operands from the register file.
- Owns a per-register pending-write scoreboard that resolves RAW and WAW hazards without per-stage forwarding.
- Delivers decoded bundles to EX through a valid/ready ID/EX register, with flush support.

Parameters:
- XLEN, 32, datapath width; instruction width fixed at 32.
- NREG, 32, architectural register count; register 0 hardwired zero.
- REG_W, 5, register index width; clog2(NREG).
- CNT_W, 2, scoreboard counter width; max outstanding writes per register = 2^CNT_W-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- in_pred_taken  in  1  fetch branch prediction.
- rf_src1, rf_src2  out  REG_W  register file read addresses (combinational).
- rf_out1, rf_out2  in  XLEN  register file read data.
- wb_valid  in  1  writeback retiring a result.
- wb_dest  in  REG_W  writeback register.
- wb_data  in  XLEN  writeback value.
- flush  in  1  squash the ID/EX register and the offered instruction.
- redirect  out  1  accepted J/JAL/JR this cycle.
- redirect_pc  out  XLEN  jump target.
- out_valid  out  1  ID/EX bundle valid.
- out_ready  in  1  EX consumes the bundle.
- out_alu_op  out  6  funct for R-type, otherwise mapped opcode.
- out_src1, out_src2  out  XLEN  ALU operands.
- out_rf_dest  out  REG_W  destination; 0 when the instruction does not write.
- out_mem_data  out  XLEN  store data.
- out_is_load, out_is_store, out_is_branch  out  1  class flags.
- out_pc  out  XLEN  instruction PC.
- out_pred_taken  out  1  registered copy of in_pred_taken.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0; all out_* = 0.
  - All scoreboard counters = 0.
  - redirect is combinational and therefore 0 while in_valid=0.
- Field decode: opcode=inst[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0].
- Register file reads:
  - rf_src1=rs.
  - rf_src2=rt for R-type, branch and store; otherwise 0.
- Destination:
  - R-type writes rd, except JR (funct 8), which writes 0.
  - JAL (3) writes 31.
  - Loads and ALU-immediate instructions write rt.
  - Stores, branches and J write 0.
- Immediate extension: zero-extend for ANDI/ORI/XORI/LUI (0x0C–0x0F); sign-extend for all other opcodes.
- Operand selection:
  - src1 = shamt zero-extended for shift funct (0,2,3), PC for JAL, otherwise rs value.
  - src2 = rt value for R-type and branch, 4 for JAL, otherwise the immediate.
- Operand bypass: a source value is taken from wb_data when wb_valid && wb_dest==src && src!=0; otherwise from rf_out.
- RAW hazard: a used source s!=0 is a hazard when cnt[s]!=0, unless cnt[s]==1 and wb_valid && wb_dest==s (last write retiring now).
- WAW/capacity hazard: stall when cnt[dest] is at its maximum and there is no wb to dest this cycle.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard && !flush.
  - Accept = in_valid && in_ready.
  - On accept, the ID/EX register loads the bundle and out_valid=1.
  - If out_ready && !accept, out_valid clears.
  - If the stalled bundle is not consumed, it holds stable (no output change while out_valid && !out_ready).
- Scoreboard update, per register r!=0:
  - +1 on accept with dest==r.
  - -1 on wb_valid with wb_dest==r.
  - -1 on flush squashing a valid ID/EX bundle with dest==r.
  - Simultaneous increment and decrement net to 0.
  - Never wraps below 0: a wb to a counter at 0 is ignored.
- Redirect: asserted in the accept cycle for J/JAL (target {pc[31:28],idx26,2'b00}) and JR (target = rs value after bypass).
- Flush:
  - Clears out_valid next edge, forces in_ready=0 and suppresses redirect.
  - wb updates still apply in the same cycle.
  - flush with out_valid=0 changes no counters.

Test Plan:
- Reset mid-stream with out_valid=1 and cnt[8]=2 -> all outputs 0 and all counters 0 immediately, before the next clk edge.
- ADDI r8,r0,5 accepted, then ADD r9,r8,r8 offered -> in_ready=0 until wb(r8, 5); in that same cycle it is accepted with out_src1=out_src2=5 and cnt[8]=0.
- ORI r3,r0,0x8000 -> out_src2=0x00008000. ADDI r3,r0,-1 -> out_src2=0xFFFFFFFF.
- Three back-to-back writes to r4 with CNT_W=2 and no wb -> the third is accepted (cnt=3); a fourth stalls until one wb.
- out_ready=0 for 4 cycles with out_valid=1 -> bundle bits stable and in_ready=0; then out_ready=1 -> next bundle issues the following edge.
- JAL at pc 0x00400010 -> redirect=1, out_rf_dest=31, src1=0x00400010, src2=4. Flush the next cycle -> out_valid=0 and cnt[31] returns to 0.
